// File: rtl/program_counter_if.sv
// program_counter_if: next-PC selection inputs and fetch status outputs of the program counter.
interface program_counter_if #(
    parameter int PC_WIDTH = 32
);
    logic                Stall;
    logic [1:0]          PC_Sel;
    logic [PC_WIDTH-1:0] PC_Plus_4;
    logic [PC_WIDTH-1:0] Branch_Target;
    logic [PC_WIDTH-1:0] Jump_Target;
    logic [PC_WIDTH-1:0] PC;
    logic                PC_Valid;
    logic                Halted;
    logic [PC_WIDTH-1:0] Fault_PC;
    logic [63:0]         Instret;

    modport master (
        output Stall, PC_Sel, PC_Plus_4, Branch_Target, Jump_Target,
        input  PC, PC_Valid, Halted, Fault_PC, Instret
    );
    modport slave (
        input  Stall, PC_Sel, PC_Plus_4, Branch_Target, Jump_Target,
        output PC, PC_Valid, Halted, Fault_PC, Instret
    );
endinterface

// File: rtl/program_counter.sv
// program_counter: fetch PC register with BOOT/RUN/HALT sequencing and a retired-cycle counter.
// Define PC_MISALIGN_TRAP_EN to halt on misaligned targets instead of forcing them word-aligned.
module program_counter #(
    parameter int                  PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input logic              clk,
    input logic              rst,
    program_counter_if.slave bus
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
    localparam logic [PC_WIDTH-1:0] BIT0 = PC_WIDTH'(1);
    localparam logic [PC_WIDTH-1:0] LOW2 = PC_WIDTH'(3);
    state_t              state, state_n;
    logic [PC_WIDTH-1:0] pc, pc_n, fault_pc, fault_pc_n, target;
    logic [63:0]         instret, instret_n;
    logic                advance;

    always_comb begin
        target = bus.PC_Sel == 2'b01 ? bus.Branch_Target :
                 bus.PC_Sel == 2'b10 ? (bus.Jump_Target & ~BIT0) : bus.PC_Plus_4;
        advance = state == RUN && !bus.Stall && bus.PC_Sel != 2'b11;
        state_n = state == BOOT ? RUN : state;
        pc_n = pc;
        instret_n = instret;
        fault_pc_n = fault_pc;
`ifdef PC_MISALIGN_TRAP_EN
        if (advance && (target & LOW2) != '0) begin
            state_n = HALT;
            fault_pc_n = pc;
        end else if (advance) begin
            pc_n = target;
            instret_n = instret + 64'd1;
        end
`else
        if (advance) begin
            pc_n = target & ~LOW2;
            instret_n = instret + 64'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
            pc <= RESET_VECTOR;
            instret <= '0;
            fault_pc <= '0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            instret <= instret_n;
            fault_pc <= fault_pc_n;
        end
    end

    assign bus.PC = pc;
    assign bus.PC_Valid = state == RUN;
    assign bus.Halted = state == HALT;
    assign bus.Fault_PC = fault_pc;
    assign bus.Instret = instret;
endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, PC and target width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h00000000, PC value loaded on reset.
REQ-003 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port Stall, input, 1, holds PC and counter when high.
REQ-006 SHALL have port PC_Sel, input, 2, next-PC source: 00 PC_Plus_4, 01 Branch_Target, 10 Jump_Target, 11 hold.
REQ-007 SHALL have port PC_Plus_4, input, PC_WIDTH, sequential address from the PC incrementer.
REQ-008 SHALL have port Branch_Target, input, PC_WIDTH, conditional branch or JAL target.
REQ-009 SHALL have port Jump_Target, input, PC_WIDTH, raw JALR sum before bit-0 clear.
REQ-010 SHALL have port PC, output, PC_WIDTH, current fetch address (registered).
REQ-011 SHALL have port PC_Valid, output, 1, high when PC is a fetchable address (state RUN).
REQ-012 SHALL have port Halted, output, 1, high in state HALT.
REQ-013 SHALL have port Fault_PC, output, PC_WIDTH, the PC of the instruction whose target faulted.
REQ-014 SHALL have port Instret, output, 64, count of retired (advanced) cycles.

Function
REQ-015 SHALL implement the states BOOT, RUN and HALT, encoded in a registered state variable.
REQ-016 BOOT SHALL last exactly one cycle: PC=RESET_VECTOR, PC_Valid=0, then go to RUN unconditionally (Stall is ignored).
REQ-017 In RUN with Stall=0, the next PC SHALL be the source selected by PC_Sel, and it SHALL appear on PC one clock edge after PC_Sel and targets are sampled.
REQ-018 Jump_Target SHALL have bit 0 forced to 0 before use; Branch_Target and PC_Plus_4 SHALL be used unmodified.
REQ-019 PC_Sel=11 or Stall=1 SHALL hold PC, and Instret SHALL NOT increment.
REQ-020 Stall SHALL take priority over PC_Sel, including over a faulting target.
REQ-021 Instret SHALL increment by 1 on each RUN cycle with Stall=0 and PC_Sel!=11. It SHALL wrap from 2^64-1 to 0 without side effects.
REQ-022 PC arithmetic SHALL NOT be done here. PC_Plus_4 wrap (FFFFFFFC to 00000000) SHALL be accepted as-is.
REQ-023 HALT SHALL hold PC, Instret and Fault_PC, and SHALL keep PC_Valid=0 and Halted=1 until rst.
REQ-024 Fault_PC SHALL be 0 outside HALT.

Reset
REQ-025 With rst=1 at a rising edge, the next state SHALL be: state=BOOT, PC=RESET_VECTOR, PC_Valid=0, Halted=0, Fault_PC=0, Instret=0.
REQ-026 rst SHALL override Stall, PC_Sel and any pending fault, in every state including HALT.
REQ-027 No output SHALL change asynchronously to clk.

Configuration
REQ-028 Macro PC_MISALIGN_TRAP_EN SHALL select misaligned-target handling.
REQ-029 With PC_MISALIGN_TRAP_EN defined, a selected (non-stalled) target with bits[1:0]!=00 in RUN SHALL instead: move to HALT, capture the current PC into Fault_PC, leave PC unchanged, and leave Instret unchanged.
REQ-030 Without PC_MISALIGN_TRAP_EN, bits[1:0] of the selected target SHALL be forced to 00, state HALT SHALL be unreachable, and Halted SHALL stay 0.

Verification
REQ-031 Reset then release with PC_Sel=00 and PC_Plus_4=PC+4 fed back -> cycle 1 BOOT with PC=00000000 and PC_Valid=0; then PC=00000000, 00000004, 00000008 with PC_Valid=1; Instret counts 1, 2, 3.
REQ-032 PC=00000008, PC_Sel=01, Branch_Target=00000100 -> PC=00000100 next edge. Then PC_Sel=10, Jump_Target=00000205 -> PC=00000204.
REQ-033 Stall=1 for 3 cycles with PC_Sel=01 and PC=00000010 -> PC stays 00000010 and Instret is unchanged. On release the branch is taken on the next edge.
REQ-034 PC=FFFFFFFC, PC_Sel=00, PC_Plus_4=00000000 -> PC=00000000 with no fault.
REQ-035 With macro defined: PC=00000040, PC_Sel=01, Branch_Target=00000102 -> Halted=1, PC_Valid=0, Fault_PC=00000040, PC stays 00000040, later inputs ignored. Without macro: PC=00000100.
REQ-036 Assert rst mid-RUN and in HALT -> next edge gives BOOT, PC=RESET_VECTOR, Instret=0, Halted=0.
